// File: rtl/wordcell_array_ctrl.sv
// Request/response front end for a bank of Wordcell words: sequences op, one-hot sel and in_bus
// so that sel is only ever asserted while op and in_bus are settled, and registers read data.
module wordcell_array_ctrl #(
    parameter int unsigned WORDS  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              op_o,
    output logic [WORDS-1:0]  sel_o,
    output logic [DATA_W-1:0] in_bus_o,
    input  logic [DATA_W-1:0] out_bus_i
);

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWStrobe,
        StWHold,
        StRSel,
        StRCap,
        StRResp
    } state_e;

    localparam logic [ADDR_W:0] WordsLim = (ADDR_W + 1)'(WORDS);

    state_e            state_q, state_d;
    logic              alive_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              in_range;
    logic              accept;
    logic [WORDS-1:0]  addr_dec;

    assign in_range = ({1'b0, addr_q} < WordsLim);
    assign accept   = req_valid_i & req_ready_o;

    // Out-of-range addresses match no bit, so the decode is all zero for them.
    always_comb begin
        addr_dec = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            addr_dec[i] = (addr_q == ADDR_W'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = req_we_i ? StWSetup : StRSel;
                end
            end
            StWSetup:  state_d = StWStrobe;
            StWStrobe: state_d = StWHold;
            StWHold:   state_d = StIdle;
            StRSel:    state_d = StRCap;
            StRCap: begin
                rdata_d = in_range ? out_bus_i : '0;
                err_d   = ~in_range;
                state_d = StRResp;
            end
            StRResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Array-side outputs decode only registered state; req_* never reach them combinationally.
    always_comb begin
        req_ready_o = alive_q & (state_q == StIdle);
        op_o        = (state_q == StWSetup) | (state_q == StWStrobe) | (state_q == StWHold);
        in_bus_o    = op_o ? wdata_q : '0;
        sel_o       = '0;
        if ((state_q == StWStrobe) | (state_q == StRSel) | (state_q == StRCap)) begin
            sel_o = addr_dec;
        end
        rsp_valid_o = (state_q == StRResp);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
    end

    // alive_q keeps req_ready low while reset is held and for the release edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            alive_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_wordcell_array_ctrl.sv
// Directed bench for wordcell_array_ctrl with a 6-word array model on the array side.
module tb_wordcell_array_ctrl;

    localparam int unsigned WORDS  = 6;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 8;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_addr;
    logic [7:0]       req_wdata;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_rdata;
    logic             rsp_err;
    logic             op;
    logic [WORDS-1:0] sel;
    logic [7:0]       in_bus;
    logic [7:0]       out_bus;

    logic [7:0]       mem     [WORDS];
    logic [7:0]       ref_mem [WORDS];

    int checks = 0;
    int errors = 0;

    logic             mon_en = 1'b0;
    logic             p_op;
    logic [WORDS-1:0] p_sel;
    logic [7:0]       p_in_bus;

    wordcell_array_ctrl #(
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .op_o        (op),
        .sel_o       (sel),
        .in_bus_o    (in_bus),
        .out_bus_i   (out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: selected words drive out_bus; a write lands when op and sel meet at an edge.
    always_comb begin
        out_bus = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (sel[i]) out_bus = out_bus | mem[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < int'(WORDS); i++) begin
            if (op && sel[i]) mem[i] <= in_bus;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sel !== p_sel) check("sel_moved_with_bus", {op, in_bus}, {p_op, p_in_bus});
            if ((op !== p_op) || (in_bus !== p_in_bus)) check("bus_moved_with_sel", {p_sel, sel}, 0);
            check("sel_onehot0", ($countones(sel) <= 1), 1);
        end
        p_op     = op;
        p_sel    = sel;
        p_in_bus = in_bus;
    end

    function automatic logic [WORDS-1:0] onehot(input logic [2:0] a);
        logic [WORDS-1:0] r;
        r = '0;
        if (a < 3'(WORDS)) r[a] = 1'b1;
        return r;
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        check("ready_timeout", req_ready, 1);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d, input logic [WORDS-1:0] es);
        wait_ready();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("w_setup_sel", sel, 0);
        check("w_setup_op", op, 1);
        check("w_setup_bus", in_bus, d);
        @(negedge clk);
        check("w_strobe_sel", sel, es);
        check("w_strobe_op", op, 1);
        check("w_strobe_bus", in_bus, d);
        @(negedge clk);
        check("w_hold_sel", sel, 0);
        check("w_hold_op", op, 1);
        check("w_hold_ready", req_ready, 0);
        @(negedge clk);
        check("w_done_ready", req_ready, 1);
        check("w_done_op", op, 0);
        if (a < 3'(WORDS)) ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [2:0] a, input int hold, input logic [WORDS-1:0] es,
                           input logic [7:0] ed, input logic ee);
        wait_ready();
        if (hold > 0) rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_wdata = 8'hEE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("r_sel_sel", sel, es);
        check("r_sel_op", op, 0);
        check("r_sel_valid", rsp_valid, 0);
        check("r_sel_ready", req_ready, 0);
        @(negedge clk);
        check("r_cap_sel", sel, es);
        check("r_cap_valid", rsp_valid, 0);
        @(negedge clk);
        check("r_resp_valid", rsp_valid, 1);
        check("r_resp_sel", sel, 0);
        check("r_resp_rdata", rsp_rdata, ed);
        check("r_resp_err", rsp_err, ee);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, ed);
            check("bp_ready", req_ready, 0);
            check("bp_sel", sel, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("r_done_valid", rsp_valid, 0);
        check("r_done_rdata", rsp_rdata, ed);
        check("r_done_ready", req_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] a;
        logic [7:0] d;
        for (int i = 0; i < int'(WORDS); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        #2;
        check("rst_ready", req_ready, 0);
        check("rst_sel", sel, 0);
        check("rst_op", op, 0);
        check("rst_bus", in_bus, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);

        // Reset in the middle of a strobe to word 2 must drop sel at once and discard the write.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 3'd2;
        req_wdata = 8'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 check("pre_rst_strobe", sel, 6'b000100);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel", sel, 0);
        check("midrst_op", op, 0);
        check("midrst_bus", in_bus, 0);
        check("midrst_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_rsp", rsp_valid, 0);
        end
        check("midrst_ready_back", req_ready, 1);
        mon_en = 1'b1;

        do_write(3'd5, 8'hA0, 6'b100000);
        do_write(3'd3, 8'h55, 6'b001000);
        do_read(3'd3, 0, 6'b001000, 8'h55, 1'b0);
        do_write(3'd3, 8'hCC, 6'b001000);
        do_read(3'd3, 0, 6'b001000, 8'hCC, 1'b0);
        do_read(3'd5, 0, 6'b100000, 8'hA0, 1'b0);
        do_read(3'd2, 0, 6'b000100, 8'h00, 1'b0);

        do_write(3'd0, 8'h3C, 6'b000001);
        do_read(3'd0, 5, 6'b000001, 8'h3C, 1'b0);

        do_write(3'd7, 8'h99, 6'b000000);
        do_read(3'd6, 0, 6'b000000, 8'h00, 1'b1);
        do_read(3'd3, 0, 6'b001000, 8'hCC, 1'b0);

        for (int n = 0; n < 200; n++) begin
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, onehot(a));
            end else begin
                do_read(a, int'($urandom_range(0, 2)), onehot(a),
                        (a < 3'(WORDS)) ? ref_mem[a] : 8'h00, (a >= 3'(WORDS)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
